// File: rtl/butterfly_pair_16bit.sv
// Pairs a serial 16-bit sample stream into (a, b) and emits registered a+b / a-b with frame tagging.
// Optional build macro BFLY_HALF_SCALE_EN: 17-bit sum/diff, result shifted right by one.
module butterfly_pair_16bit #(
    parameter int FRAME_PAIRS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic [15:0] out_diff,
    output logic        out_last
);

    typedef enum logic {
        WAIT_A = 1'b0,
        HAVE_A = 1'b1
    } pair_state_t;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_PAIRS - 1);

`ifdef BFLY_HALF_SCALE_EN
    function automatic logic [15:0] calc_sum(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[16:1];
    endfunction

    function automatic logic [15:0] calc_diff(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        t = {1'b0, a} - {1'b0, b};
        return t[16:1];
    endfunction
`else
    function automatic logic [15:0] calc_sum(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    function automatic logic [15:0] calc_diff(input logic [15:0] a, input logic [15:0] b);
        return a - b;
    endfunction
`endif

    pair_state_t state_r;
    logic [15:0] a_r;
    logic [15:0] pair_idx_r;
    logic        out_valid_r;
    logic [15:0] sum_r;
    logic [15:0] diff_r;
    logic        last_r;

    logic        in_ready_s;
    logic        accept_s;
    logic        load_s;

    // Handshake decode: b may only enter when the output slot is free or draining.
    always_comb begin
        in_ready_s = (state_r == WAIT_A) | ~out_valid_r | out_ready;
        accept_s   = in_valid & in_ready_s;
        if (state_r == HAVE_A) begin
            load_s = accept_s;
        end else begin
            load_s = 1'b0;
        end
    end

    // Pair collection state and held a sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_A;
            a_r     <= 16'h0000;
        end else begin
            case (state_r)
                WAIT_A: begin
                    if (accept_s) begin
                        a_r     <= in_data;
                        state_r <= HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (accept_s) begin
                        state_r <= WAIT_A;
                    end
                end
                default: state_r <= WAIT_A;
            endcase
        end
    end

    // Output register and frame position; a load and a retire on one edge keep out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            sum_r       <= 16'h0000;
            diff_r      <= 16'h0000;
            last_r      <= 1'b0;
            pair_idx_r  <= 16'h0000;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            sum_r       <= calc_sum(a_r, in_data);
            diff_r      <= calc_diff(a_r, in_data);
            last_r      <= (pair_idx_r == LAST_IDX);
            if (pair_idx_r == LAST_IDX) begin
                pair_idx_r <= 16'h0000;
            end else begin
                pair_idx_r <= pair_idx_r + 16'h0001;
            end
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_sum   = sum_r;
    assign out_diff  = diff_r;
    assign out_last  = last_r;

endmodule

// File: tb/tb_butterfly_pair_16bit.sv
// Directed bench for butterfly_pair_16bit: pair-level reference model plus literal spot checks.
module tb_butterfly_pair_16bit;

    localparam int FRAME = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_last;
    logic [15:0] out_sum, out_diff;
    logic        in_ready1, out_valid1, out_last1;
    logic [15:0] out_sum1, out_diff1;

    int vectors = 0;
    int fails = 0;

    butterfly_pair_16bit #(.FRAME_PAIRS(FRAME)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_diff(out_diff),
        .out_last(out_last)
    );

    butterfly_pair_16bit #(.FRAME_PAIRS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1), .out_diff(out_diff1),
        .out_last(out_last1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] f_sum(input int a, input int b);
`ifdef BFLY_HALF_SCALE_EN
        return 16'((a + b) / 2);
`else
        return 16'((a + b) % 65536);
`endif
    endfunction

    function automatic logic [15:0] f_diff(input int a, input int b);
`ifdef BFLY_HALF_SCALE_EN
        return 16'(((a - b + 131072) % 131072) / 2);
`else
        return 16'((a - b + 65536) % 65536);
`endif
    endfunction

    // Reference model: tracks whether an a is held and what the output slot should contain.
    bit          started = 1'b0;
    bit          m_have_a = 1'b0;
    int          m_a = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_sum = 16'h0000;
    logic [15:0] m_diff = 16'h0000;
    bit          m_last = 1'b0;
    int          m_pairs = 0;

    always @(posedge clk) begin
        bit ready, take;
        if (rst) begin
            started  = 1'b1;
            m_have_a = 1'b0;
            m_a      = 0;
            m_valid  = 1'b0;
            m_sum    = 16'h0000;
            m_diff   = 16'h0000;
            m_last   = 1'b0;
            m_pairs  = 0;
        end else if (started) begin
            ready = !m_have_a || !m_valid || out_ready;
            take  = in_valid && ready;
            if (take && m_have_a) begin
                m_sum    = f_sum(m_a, int'(in_data));
                m_diff   = f_diff(m_a, int'(in_data));
                m_last   = ((m_pairs % FRAME) == FRAME - 1);
                m_pairs  = m_pairs + 1;
                m_valid  = 1'b1;
                m_have_a = 1'b0;
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (take) begin
                    m_a      = int'(in_data);
                    m_have_a = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("in_ready", 16'(in_ready), 16'(!m_have_a || !m_valid || out_ready));
            chk("out_valid", 16'(out_valid), 16'(m_valid));
            chk("out_valid_fp1", 16'(out_valid1), 16'(m_valid));
            if (m_valid) begin
                chk("out_sum", out_sum, m_sum);
                chk("out_diff", out_diff, m_diff);
                chk("out_last", 16'(out_last), 16'(m_last));
                chk("out_last_fp1", 16'(out_last1), 16'(1));
            end
        end
    end

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents one sample and waits (bounded) for its acceptance; returns just after the accepting edge.
    task automatic send(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        vectors++;
        if (!ok) begin
            fails++;
            $display("FAIL send_timeout: got no acceptance, expected acceptance of %h", d);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        do_reset(2);
        chk("rst_valid", 16'(out_valid), 16'h0000);
        chk("rst_sum", out_sum, 16'h0000);
        chk("rst_diff", out_diff, 16'h0000);
        chk("rst_last", 16'(out_last), 16'h0000);
        chk("rst_ready", 16'(in_ready), 16'h0001);

        // Basic pair, wrap, negative difference.
        send(16'h1000); send(16'h0400);
        chk("basic_valid", 16'(out_valid), 16'h0001);
`ifdef BFLY_HALF_SCALE_EN
        chk("basic_sum", out_sum, 16'h0A00);
        chk("basic_diff", out_diff, 16'h0600);
`else
        chk("basic_sum", out_sum, 16'h1400);
        chk("basic_diff", out_diff, 16'h0C00);
`endif
        chk("basic_last", 16'(out_last), 16'h0000);
        send(16'hFFFF); send(16'h0002);
`ifdef BFLY_HALF_SCALE_EN
        chk("wrap_sum", out_sum, 16'h8000);
        chk("wrap_diff", out_diff, 16'h7FFE);
`else
        chk("wrap_sum", out_sum, 16'h0001);
        chk("wrap_diff", out_diff, 16'hFFFD);
`endif
        send(16'h0002); send(16'h0004);
`ifdef BFLY_HALF_SCALE_EN
        chk("neg_sum", out_sum, 16'h0003);
        chk("neg_diff", out_diff, 16'hFFFF);
`else
        chk("neg_sum", out_sum, 16'h0006);
        chk("neg_diff", out_diff, 16'hFFFE);
`endif

        // Backpressure: b blocked while the slot is full, then swap on one edge.
        do_reset(1);
        send(16'h0010); send(16'h0003);
        out_ready = 1'b0;
        send(16'h0100);
        in_valid = 1'b1;
        in_data  = 16'h0001;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", 16'(in_ready), 16'h0000);
            chk("bp_valid", 16'(out_valid), 16'h0001);
`ifdef BFLY_HALF_SCALE_EN
            chk("bp_hold_sum", out_sum, 16'h0009);
`else
            chk("bp_hold_sum", out_sum, 16'h0013);
`endif
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 16'(in_ready), 16'h0001);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_swap_valid", 16'(out_valid), 16'h0001);
`ifdef BFLY_HALF_SCALE_EN
        chk("bp_swap_sum", out_sum, 16'h0080);
        chk("bp_swap_diff", out_diff, 16'h007F);
`else
        chk("bp_swap_sum", out_sum, 16'h0101);
        chk("bp_swap_diff", out_diff, 16'h00FF);
`endif

        // Frame tagging over ten pairs; last on pairs 4 and 8.
        do_reset(1);
        for (int k = 0; k < 10; k++) begin
            send(16'(k * 37 + 5));
            send(16'(k * 11 + 1));
            chk("frame_last", 16'(out_last), 16'((k == 3) || (k == 7)));
        end

        // Reset with a half-collected pair.
        @(posedge clk);
        #1;
        send(16'h1234);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(16'h0001); send(16'h0001);
        chk("mid_rst_valid", 16'(out_valid), 16'h0001);
`ifdef BFLY_HALF_SCALE_EN
        chk("mid_rst_sum", out_sum, 16'h0001);
`else
        chk("mid_rst_sum", out_sum, 16'h0002);
`endif
        chk("mid_rst_diff", out_diff, 16'h0000);
        @(posedge clk);
        #1;
        chk("mid_rst_single", 16'(out_valid), 16'h0000);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected $finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
